// File: rtl/contador_regressivo_bcd.sv
// ---------------------------------------------------------------------------
// contador_regressivo_bcd
//
// Parametrised multi-digit cascaded BCD down-counter for the timer datapath.
// Each digit has its own modulus, so one instance can count down mm:ss, ss,
// or a plain decimal value. Digit 0 is the least significant digit.
//
// Parameters:
//   DIGITS : number of cascaded digits (1..8)
//   MODS   : packed per-digit modulus, 4 bits per digit (legal 2..10, 4'hA = 10)
//
// Ports:
//   clk       : system clock, rising edge
//   clear     : asynchronous active-high reset
//   data      : BCD preset value, digit i at data[4i+3:4i]
//   load      : active-low synchronous load (wins over enable)
//   enable    : one decrement per cycle while high
//   count     : current BCD value
//   count_end : combinational, high when count is all zero
//   done      : registered one-cycle pulse when a decrement reaches zero
//   running   : registered, high while enabled and next count is non-zero
//
// Optional feature macro: CONTADOR_AUTO_RELOAD_EN
//   When defined, a shadow register keeps the last clamped load value and the
//   counter reloads from it when enabled at zero instead of holding.
// ---------------------------------------------------------------------------
module contador_regressivo_bcd #(
  parameter int          DIGITS = 4,
  parameter logic [31:0] MODS   = 32'h00006A6A
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic [4*DIGITS-1:0]   data,
  input  logic                  load,
  input  logic                  enable,
  output logic [4*DIGITS-1:0]   count,
  output logic                  count_end,
  output logic                  done,
  output logic                  running
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0] count_q, count_d;
  logic         done_q, done_d;
  logic         running_q, running_d;

  logic [W-1:0] clampedVal;
  logic [W-1:0] decVal;
  logic [W-1:0] zeroFill;
  logic         countZero;

  logic [3:0]   modI;
  logic [3:0]   maxI;
  logic [3:0]   dIn;
  logic [3:0]   dCur;
  logic         borrow;

  assign countZero = (count_q == '0);

  // Per-digit clamp of the preset and the ripple-borrow decrement. The borrow
  // into digit i is set only when every lower digit of the current count is
  // zero; a borrowed digit at zero wraps to its own modulus minus one.
  always_comb begin
    clampedVal = '0;
    decVal     = '0;
    modI       = '0;
    maxI       = '0;
    dIn        = '0;
    dCur       = '0;
    borrow     = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      modI = MODS[4*i +: 4];
      maxI = modI - 4'd1;
      dIn  = data[4*i +: 4];
      dCur = count_q[4*i +: 4];
      clampedVal[4*i +: 4] = (dIn >= modI) ? maxI : dIn;
      if (borrow) begin
        decVal[4*i +: 4] = (dCur == 4'd0) ? maxI : (dCur - 4'd1);
      end else begin
        decVal[4*i +: 4] = dCur;
      end
      borrow = borrow & (dCur == 4'd0);
    end
  end

`ifdef CONTADOR_AUTO_RELOAD_EN
  logic [W-1:0] shadow_q;

  // Shadow copy of every clamped load; enabling at zero restarts from it.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      shadow_q <= '0;
    end else if (!load) begin
      shadow_q <= clampedVal;
    end
  end

  assign zeroFill = shadow_q;
`else
  // Without the shadow, enabling at zero simply holds zero.
  assign zeroFill = '0;
`endif

  // Next-state selection: load beats enable beats hold. done only fires when
  // a real decrement from a non-zero count lands on zero, never on a load or
  // on a reload from the shadow.
  always_comb begin
    count_d = count_q;
    done_d  = 1'b0;
    if (!load) begin
      count_d = clampedVal;
    end else if (enable) begin
      if (countZero) begin
        count_d = zeroFill;
      end else begin
        count_d = decVal;
        done_d  = (decVal == '0);
      end
    end
    running_d = enable & (count_d != '0);
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      count_q   <= '0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      done_q    <= done_d;
      running_q <= running_d;
    end
  end

  assign count     = count_q;
  assign count_end = countZero;
  assign done      = done_q;
  assign running   = running_q;

endmodule

// File: tb/tb_contador_regressivo_bcd.sv
// ---------------------------------------------------------------------------
// tb_contador_regressivo_bcd
//
// Self-checking bench for contador_regressivo_bcd with default parameters
// (4 digits, moduli 10/6/10/6 from least to most significant). The reference
// model treats the count as a mixed-radix integer: decrement is value-1, and
// BCD digits are recovered by repeated division by each digit's modulus.
// Honours CONTADOR_AUTO_RELOAD_EN when it is defined for the build.
// ---------------------------------------------------------------------------
module tb_contador_regressivo_bcd;

  logic        clk;
  logic        clear;
  logic [15:0] data;
  logic        load;
  logic        enable;
  logic [15:0] count;
  logic        countEnd;
  logic        done;
  logic        running;

  int testCount = 0;
  int failCount = 0;

  // Digit moduli from least significant digit upward (MODS = 32'h00006A6A).
  int mods [4] = '{10, 6, 10, 6};

  // Reference model state.
  logic [15:0] mCount;
  logic        mDone;
  logic        mRunning;
  logic [15:0] mShadow;

  contador_regressivo_bcd #(
    .DIGITS(4),
    .MODS  (32'h00006A6A)
  ) dut (
    .clk      (clk),
    .clear    (clear),
    .data     (data),
    .load     (load),
    .enable   (enable),
    .count    (count),
    .count_end(countEnd),
    .done     (done),
    .running  (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Mixed-radix value of a BCD count.
  function automatic int toValue(input logic [15:0] c);
    int v = 0;
    int w = 1;
    for (int i = 0; i < 4; i++) begin
      v = v + int'(c[4*i +: 4]) * w;
      w = w * mods[i];
    end
    return v;
  endfunction

  // BCD digits of a mixed-radix value.
  function automatic logic [15:0] fromValue(input int v);
    logic [15:0] c = '0;
    int          r = v;
    for (int i = 0; i < 4; i++) begin
      c[4*i +: 4] = 4'(r % mods[i]);
      r = r / mods[i];
    end
    return c;
  endfunction

  // Each preset digit saturates at its modulus minus one.
  function automatic logic [15:0] clampData(input logic [15:0] d);
    logic [15:0] c = '0;
    int          dig;
    for (int i = 0; i < 4; i++) begin
      dig = int'(d[4*i +: 4]);
      if (dig > mods[i] - 1) dig = mods[i] - 1;
      c[4*i +: 4] = 4'(dig);
    end
    return c;
  endfunction

  function automatic void modelReset();
    mCount   = '0;
    mDone    = 1'b0;
    mRunning = 1'b0;
    mShadow  = '0;
  endfunction

  // One rising edge of the reference model.
  function automatic void modelStep(input logic l, input logic e, input logic [15:0] d);
    int v;
    mDone = 1'b0;
    if (!l) begin
      mCount  = clampData(d);
      mShadow = mCount;
    end else if (e) begin
      v = toValue(mCount);
      if (v > 0) begin
        mCount = fromValue(v - 1);
        mDone  = (v - 1 == 0);
      end else begin
`ifdef CONTADOR_AUTO_RELOAD_EN
        mCount = mShadow;
`else
        mCount = '0;
`endif
      end
    end
    mRunning = e && (toValue(mCount) != 0);
  endfunction

  // Drive one cycle of inputs, advance the model at the edge and return
  // 1 time unit after the edge so outputs are sampled away from it.
  task automatic applyStimulus(input logic l, input logic e, input logic [15:0] d);
    load   = l;
    enable = e;
    data   = d;
    @(posedge clk);
    modelStep(l, e, d);
    #1;
  endtask

  task automatic test_reset();
    clear  = 1'b1;
    load   = 1'b1;
    enable = 1'b0;
    data   = '0;
    modelReset();
    #12;
    testCount++;
    if (count !== 16'h0000) begin
      $display("[TB] FAIL reset_count got=%h exp=%h", count, 16'h0000); failCount++;
    end
    testCount++;
    if (countEnd !== 1'b1) begin
      $display("[TB] FAIL reset_count_end got=%b exp=%b", countEnd, 1'b1); failCount++;
    end
    testCount++;
    if (done !== 1'b0) begin
      $display("[TB] FAIL reset_done got=%b exp=%b", done, 1'b0); failCount++;
    end
    testCount++;
    if (running !== 1'b0) begin
      $display("[TB] FAIL reset_running got=%b exp=%b", running, 1'b0); failCount++;
    end
    clear = 1'b0;
  endtask

  task automatic test_load_decrement();
    applyStimulus(1'b0, 1'b0, 16'h0100);
    testCount++;
    if (count !== 16'h0100) begin
      $display("[TB] FAIL load_0100 got=%h exp=%h", count, 16'h0100); failCount++;
    end
    applyStimulus(1'b1, 1'b1, 16'($urandom));
    testCount++;
    if (count !== 16'h0059) begin
      $display("[TB] FAIL first_dec got=%h exp=%h", count, 16'h0059); failCount++;
    end
    applyStimulus(1'b1, 1'b1, 16'($urandom));
    testCount++;
    if (count !== 16'h0058) begin
      $display("[TB] FAIL second_dec got=%h exp=%h", count, 16'h0058); failCount++;
    end
  endtask

  task automatic test_zero_hold();
    logic [15:0] expSeq [5] = '{16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    logic        expDone[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    applyStimulus(1'b0, 1'b0, 16'h0002);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 1'b1, 16'($urandom));
`ifndef CONTADOR_AUTO_RELOAD_EN
      testCount++;
      if (count !== expSeq[k]) begin
        $display("[TB] FAIL zero_hold_count step=%0d got=%h exp=%h", k, count, expSeq[k]); failCount++;
      end
      testCount++;
      if (done !== expDone[k]) begin
        $display("[TB] FAIL zero_hold_done step=%0d got=%b exp=%b", k, done, expDone[k]); failCount++;
      end
`endif
      testCount++;
      if (running !== mRunning) begin
        $display("[TB] FAIL zero_hold_running step=%0d got=%b exp=%b", k, running, mRunning); failCount++;
      end
      testCount++;
      if (countEnd !== (toValue(mCount) == 0)) begin
        $display("[TB] FAIL zero_hold_count_end step=%0d got=%b exp=%b", k, countEnd, (toValue(mCount) == 0)); failCount++;
      end
    end
  endtask

  task automatic test_clamp();
    applyStimulus(1'b0, 1'b0, 16'h9F9F);
    testCount++;
    if (count !== 16'h5959) begin
      $display("[TB] FAIL clamp_9F9F got=%h exp=%h", count, 16'h5959); failCount++;
    end
    applyStimulus(1'b0, 1'b1, 16'h0000);
    testCount++;
    if (count !== 16'h0000) begin
      $display("[TB] FAIL load_zero_count got=%h exp=%h", count, 16'h0000); failCount++;
    end
    testCount++;
    if (done !== 1'b0) begin
      $display("[TB] FAIL load_zero_done got=%b exp=%b", done, 1'b0); failCount++;
    end
  endtask

  task automatic test_borrow();
    applyStimulus(1'b0, 1'b0, 16'h1000);
    applyStimulus(1'b1, 1'b1, 16'h0000);
    testCount++;
    if (count !== 16'h0959) begin
      $display("[TB] FAIL borrow_1000 got=%h exp=%h", count, 16'h0959); failCount++;
    end
  endtask

  task automatic test_load_vs_enable();
    applyStimulus(1'b0, 1'b0, 16'h0145);
    applyStimulus(1'b0, 1'b1, 16'h0030);
    testCount++;
    if (count !== 16'h0030) begin
      $display("[TB] FAIL load_wins got=%h exp=%h", count, 16'h0030); failCount++;
    end
    testCount++;
    if (running !== 1'b1) begin
      $display("[TB] FAIL load_wins_running got=%b exp=%b", running, 1'b1); failCount++;
    end
  endtask

  task automatic test_async_clear();
    applyStimulus(1'b0, 1'b0, 16'h1000);
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b1, 16'h0000);
    #3;
    clear = 1'b1;
    #1;
    modelReset();
    testCount++;
    if (count !== 16'h0000) begin
      $display("[TB] FAIL clear_count got=%h exp=%h", count, 16'h0000); failCount++;
    end
    testCount++;
    if (done !== 1'b0) begin
      $display("[TB] FAIL clear_done got=%b exp=%b", done, 1'b0); failCount++;
    end
    testCount++;
    if (running !== 1'b0) begin
      $display("[TB] FAIL clear_running got=%b exp=%b", running, 1'b0); failCount++;
    end
    testCount++;
    if (countEnd !== 1'b1) begin
      $display("[TB] FAIL clear_count_end got=%b exp=%b", countEnd, 1'b1); failCount++;
    end
    #2;
    clear = 1'b0;
  endtask

`ifdef CONTADOR_AUTO_RELOAD_EN
  task automatic test_auto_reload();
    logic [15:0] expSeq [5] = '{16'h0001, 16'h0000, 16'h0002, 16'h0001, 16'h0000};
    logic        expDone[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    applyStimulus(1'b0, 1'b0, 16'h0002);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 1'b1, 16'h0000);
      testCount++;
      if (count !== expSeq[k]) begin
        $display("[TB] FAIL reload_count step=%0d got=%h exp=%h", k, count, expSeq[k]); failCount++;
      end
      testCount++;
      if (done !== expDone[k]) begin
        $display("[TB] FAIL reload_done step=%0d got=%b exp=%b", k, done, expDone[k]); failCount++;
      end
    end
  endtask
`endif

  // Random loads (including out-of-range digits) and enables against the model.
  task automatic test_random();
    logic        l;
    logic        e;
    logic [15:0] d;
    for (int cyc = 0; cyc < 300; cyc++) begin
      l = ($urandom_range(0, 15) != 0);
      e = ($urandom_range(0, 3) != 0);
      d = ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'($urandom_range(0, 3));
      applyStimulus(l, e, d);
      testCount++;
      if (count !== mCount) begin
        $display("[TB] FAIL rand_count cyc=%0d got=%h exp=%h", cyc, count, mCount); failCount++;
      end
      testCount++;
      if (done !== mDone) begin
        $display("[TB] FAIL rand_done cyc=%0d got=%b exp=%b", cyc, done, mDone); failCount++;
      end
      testCount++;
      if (running !== mRunning) begin
        $display("[TB] FAIL rand_running cyc=%0d got=%b exp=%b", cyc, running, mRunning); failCount++;
      end
      testCount++;
      if (countEnd !== (toValue(mCount) == 0)) begin
        $display("[TB] FAIL rand_count_end cyc=%0d got=%b exp=%b", cyc, countEnd, (toValue(mCount) == 0)); failCount++;
      end
    end
  endtask

  // Scenario sequence.
  initial begin
    test_reset();
    test_load_decrement();
    test_zero_hold();
    test_clamp();
    test_borrow();
    test_load_vs_enable();
    test_async_clear();
`ifdef CONTADOR_AUTO_RELOAD_EN
    test_auto_reload();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
